hazard_controller: RTL

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - pipeline interlock, bypass select, branch flush and halt drain
// Optional forwarding is enabled by defining HAZARD_BYPASS_EN.
module hazard_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic       decValid,
  input  logic [4:0] rs1Addr,
  input  logic [4:0] rs2Addr,
  input  logic [4:0] decRdAddr,
  input  logic       decWEnable,
  input  logic       decIsLoad,
  input  logic       decIsForwardable,
  input  logic       decIsHalt,
  input  logic       brTaken,
  output logic       isDataHazard,
  output logic [1:0] op1BypassCtrl,
  output logic [1:0] op2BypassCtrl,
  output logic       flush,
  output logic       fetchStall,
  output logic       halted
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       w_enable;
    logic       is_load;
    logic       is_fwd;
    logic       is_halt;
  } entry_t;

  typedef enum logic [1:0] {RUN, FLUSH, HALT_DRAIN, HALTED} state_t;

  entry_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  state_t state_q, state_d;

  logic [2:0] hit1, hit2;
  logic       hazard_raw;
  logic       issue;
  logic       squash_ex;
  logic       halt_stall;
  logic       br;

  function automatic logic hit(entry_t e, logic [4:0] rs);
    return e.valid && e.w_enable && (e.rd == rs) && (rs != 5'd0);
  endfunction

  function automatic logic [1:0] youngest(logic [2:0] h);
    if (h[0])      return 2'd1;
    else if (h[1]) return 2'd2;
    else if (h[2]) return 2'd3;
    else           return 2'd0;
  endfunction

  // bit 0 = EX, bit 1 = MEM, bit 2 = WB
  always_comb begin
    hit1 = {hit(wb_q, rs1Addr), hit(mem_q, rs1Addr), hit(ex_q, rs1Addr)};
    hit2 = {hit(wb_q, rs2Addr), hit(mem_q, rs2Addr), hit(ex_q, rs2Addr)};
`ifdef HAZARD_BYPASS_EN
    op1BypassCtrl = youngest(hit1);
    op2BypassCtrl = youngest(hit2);
    hazard_raw    = decValid &&
                    (((hit1[0] || hit2[0]) && (ex_q.is_load || !ex_q.is_fwd)) ||
                     ((hit1[1] || hit2[1]) && mem_q.is_load));
`else
    op1BypassCtrl = 2'd0;
    op2BypassCtrl = 2'd0;
    hazard_raw    = decValid && ((hit1 | hit2) != 3'b000);
`endif
  end

  // Reset must silence flush even though brTaken feeds it combinationally.
  assign br = brTaken && rst;

  always_comb begin
    state_d      = state_q;
    flush        = 1'b0;
    isDataHazard = 1'b0;
    halted       = 1'b0;
    halt_stall   = 1'b0;
    issue        = 1'b0;
    squash_ex    = 1'b0;
    case (state_q)
      RUN: begin
        if (br) begin
          flush     = 1'b1;
          squash_ex = 1'b1;
          state_d   = FLUSH;
        end else begin
          isDataHazard = hazard_raw;
          issue        = decValid && !hazard_raw;
          if (issue && decIsHalt) state_d = HALT_DRAIN;
        end
      end
      FLUSH: begin
        flush   = 1'b1;
        state_d = RUN;
      end
      HALT_DRAIN: begin
        halt_stall = 1'b1;
        if (br && ex_q.valid && ex_q.is_halt) begin
          flush     = 1'b1;
          squash_ex = 1'b1;
          state_d   = FLUSH;
        end else if (mem_q.valid && mem_q.is_halt) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        halt_stall = 1'b1;
        halted     = 1'b1;
      end
      default: state_d = RUN;
    endcase
    fetchStall = isDataHazard || halt_stall;
  end

  always_comb begin
    ex_d = '0;
    if (issue) begin
      ex_d.valid    = 1'b1;
      ex_d.rd       = decRdAddr;
      ex_d.w_enable = decWEnable;
      ex_d.is_load  = decIsLoad;
      ex_d.is_fwd   = decIsForwardable;
      ex_d.is_halt  = decIsHalt;
    end
    mem_d = squash_ex ? '0 : ex_q;
    wb_d  = mem_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
    end
  end

endmodule
